alu: RTL and testbench

//  Registered 32-bit integer ALU for the datapath execute stage.

---
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit integer ALU for the execute stage: one-cycle latency, Equal/Carry/Overflow flags.
// Optional multiplier on opcode 11 enabled by defining ALU_MUL_EN.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [3:0]       ALUopsel,
  output logic [WIDTH-1:0] ALUresult,
  output logic             Equal,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
`endif

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;
  logic             w_equal;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] w_prod;
`endif

  logic [WIDTH-1:0] r_result;
  logic             r_equal;
  logic             r_carry;
  logic             r_ovf;

  // Subtraction as A + ~B + 1 so the top bit reads directly as "no borrow".
  assign w_sum   = {1'b0, OperandA} + {1'b0, OperandB};
  assign w_dif   = {1'b0, OperandA} + {1'b0, ~OperandB} + {{WIDTH{1'b0}}, 1'b1};
  assign w_sh    = OperandB[SHW-1:0];
  assign w_equal = (OperandA == OperandB);
`ifdef ALU_MUL_EN
  assign w_prod  = OperandA * OperandB;
`endif

  // Next result and flags from the current opcode
  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (ALUopsel)
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
        w_ovf    = (OperandA[WIDTH-1] == OperandB[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != OperandA[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_dif[WIDTH-1:0];
        w_carry  = w_dif[WIDTH];
        w_ovf    = (OperandA[WIDTH-1] != OperandB[WIDTH-1]) &&
                   (w_dif[WIDTH-1] != OperandA[WIDTH-1]);
      end
      OP_AND:  w_result = OperandA & OperandB;
      OP_OR:   w_result = OperandA | OperandB;
      OP_XOR:  w_result = OperandA ^ OperandB;
      OP_NOR:  w_result = ~(OperandA | OperandB);
      OP_SLL:  w_result = OperandA << w_sh;
      OP_SRL:  w_result = OperandA >> w_sh;
      OP_SRA:  w_result = $unsigned($signed(OperandA) >>> w_sh);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(OperandA) < $signed(OperandB))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (OperandA < OperandB)};
`ifdef ALU_MUL_EN
      OP_MUL:  w_result = w_prod;
`endif
      default: begin
        w_result = {WIDTH{1'b0}};
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
      end
    endcase
  end

  // Output register with synchronous reset taking priority over the operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= {WIDTH{1'b0}};
      r_equal  <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_equal  <= w_equal;
      r_carry  <= w_carry;
      r_ovf    <= w_ovf;
    end
  end

  assign ALUresult = r_result;
  assign Equal     = r_equal;
  assign Carry     = r_carry;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic [3:0]  ALUopsel;
  logic [31:0] ALUresult;
  logic        Equal;
  logic        Carry;
  logic        Overflow;

  int n_tests;
  int n_fail;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .ALUopsel (ALUopsel),
    .ALUresult(ALUresult),
    .Equal    (Equal),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result, equal, carry, overflow} from plain wide arithmetic
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, s;
    logic [31:0] r;
    logic        c, o;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = 32'd0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) > 64'sd4294967295;
        s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd11: r = 32'(longint'(a) * longint'(b));
`endif
      default: r = 32'd0;
    endcase
    return {r, (a == b), c, o};
  endfunction

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUopsel = op;
    OperandA = a;
    OperandB = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [34:0] exp);
    logic [34:0] got;
    got = {ALUresult, Equal, Carry, Overflow};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got res=%h eq=%b c=%b v=%b, expected res=%h eq=%b c=%b v=%b",
             tag, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  logic [31:0] sweep_exp [0:10];
  logic [31:0] ra, rb;
  logic [3:0]  rop;
  logic [34:0] mul_exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sweep_exp[0] = 32'd2;  sweep_exp[1] = 32'd0;  sweep_exp[2]  = 32'd1;
    sweep_exp[3] = 32'd1;  sweep_exp[4] = 32'd0;  sweep_exp[5]  = 32'hFFFF_FFFE;
    sweep_exp[6] = 32'd2;  sweep_exp[7] = 32'd0;  sweep_exp[8]  = 32'd0;
    sweep_exp[9] = 32'd0;  sweep_exp[10] = 32'd0;

    // Reset held two cycles with random operands on the inputs
    reset = 1'b1;
    step(4'd0, $urandom, $urandom);
    check("reset_c1", 35'd0);
    step(4'd1, $urandom, $urandom);
    check("reset_c2", 35'd0);

    reset = 1'b0;
    step(4'd0, 32'd5, 32'd7);
    check("first_after_reset", {32'd12, 1'b0, 1'b0, 1'b0});

    for (int op = 0; op <= 10; op++) begin
      step(4'(op), 32'd1, 32'd1);
      check($sformatf("sweep_op%0d", op), {sweep_exp[op], 1'b1, (op == 1), 1'b0});
    end

    step(4'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap", {32'd0, 1'b0, 1'b1, 1'b0});
    step(4'd0, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf", {32'h8000_0000, 1'b0, 1'b0, 1'b1});
    step(4'd1, 32'd0, 32'd1);
    check("sub_borrow", {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    step(4'd1, 32'h8000_0000, 32'd1);
    check("sub_ovf", {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1});
    step(4'd8, 32'h8000_0000, 32'd31);
    check("sra_31", {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    step(4'd7, 32'h8000_0000, 32'd31);
    check("srl_31", {32'd1, 1'b0, 1'b0, 1'b0});
    step(4'd6, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    check("sll_sh0_upper_ignored", {32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0});
    step(4'd9, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg", {32'd1, 1'b0, 1'b0, 1'b0});
    step(4'd10, 32'hFFFF_FFFF, 32'd1);
    check("sltu_big", {32'd0, 1'b0, 1'b0, 1'b0});

`ifdef ALU_MUL_EN
    mul_exp = {32'd15, 1'b0, 1'b0, 1'b0};
`else
    mul_exp = 35'd0;
`endif
    step(4'd11, 32'd3, 32'd5);
    check("op11", mul_exp);
    step(4'd15, 32'd3, 32'd5);
    check("op15_reserved", 35'd0);
    step(4'd13, 32'h1234_5678, 32'h1234_5678);
    check("op13_equal", {32'd0, 1'b1, 1'b0, 1'b0});

    // Reset asserted mid-stream overrides the operation presented that cycle
    reset = 1'b1;
    step(4'd0, 32'd9, 32'd9);
    check("reset_override", 35'd0);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (($urandom & 32'd7) == 32'd0) ? ra : $urandom;
      if (($urandom & 32'd3) == 32'd0) ra = ra ^ 32'h8000_0000;
      step(rop, ra, rb);
      check($sformatf("rand%0d_op%0d", i, rop), model(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
